// File: rtl/music_pkg.sv
// Shared types and default constants for the background-music playback path
// (sequencer, sample ROM and audio serializer).
package music_pkg;

  localparam int CLK_HZ_DEF    = 50_000_000;
  localparam int SAMPLE_HZ_DEF = 16_000;
  localparam int TRACK_LEN_DEF = 80550;
  localparam int ADDR_W_DEF    = 17;
  localparam int DATA_W_DEF    = 17;

  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  localparam int DIV_DEF = calc_div(CLK_HZ_DEF, SAMPLE_HZ_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_FETCH,
    ST_CAPTURE,
    ST_PRESENT,
    ST_PAUSED
  } music_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 while run_i is high, holds while idle,
// and clear_i forces it back to zero (clear wins over run).
module sample_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = run_i && (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/music_player_ctrl.sv
// Background-music playback sequencer: paces reads of the sample ROM at the
// audio rate and presents each sample to the serializer.
module music_player_ctrl
  import music_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int SAMPLE_HZ = SAMPLE_HZ_DEF,
  parameter int TRACK_LEN = TRACK_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output music_state_t      state_dbg
);

  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TRACK_LEN - 1);

  music_state_t      state_q;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] sample_q;
  logic              valid_q;
  logic              done_q;
  logic              underrun_q;
  logic              pause_pend_q;

  logic tick;
  logic div_run;
  logic div_clear;
  logic accept;

  assign div_run   = state_q inside {ST_WAIT_TICK, ST_FETCH, ST_CAPTURE, ST_PRESENT};
  assign div_clear = (state_q == ST_IDLE) || stop;

  sample_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .run_i  (div_run),
    .clear_i(div_clear),
    .tick_o (tick)
  );

  // Handshake: a sample transfers on a cycle where sample_valid && sample_ready;
  // once raised, sample_valid and sample_out stay stable until that transfer
  // (only stop or reset may withdraw it).
  assign accept = valid_q && sample_ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A tick outside WAIT_TICK means the previous sample is still in flight.
      if (tick && (state_q != ST_WAIT_TICK)) underrun_q <= 1'b1;

      if (stop) begin
        state_q      <= ST_IDLE;
        index_q      <= '0;
        valid_q      <= 1'b0;
        pause_pend_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (play) begin
              index_q    <= '0;
              underrun_q <= 1'b0;
              state_q    <= ST_WAIT_TICK;
            end
          end
          ST_WAIT_TICK: begin
            if (pause)     state_q <= ST_PAUSED;
            else if (tick) state_q <= ST_FETCH;
          end
          ST_FETCH: begin
            state_q <= pause ? ST_PAUSED : ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (pause) begin
              state_q <= ST_PAUSED;
            end else begin
              sample_q <= rom_data;
              valid_q  <= 1'b1;
              state_q  <= ST_PRESENT;
            end
          end
          ST_PRESENT: begin
            if (pause) pause_pend_q <= 1'b1;
            if (accept) begin
              valid_q      <= 1'b0;
              pause_pend_q <= 1'b0;
              if ((index_q == LAST_IDX) && !loop_en) begin
                done_q  <= 1'b1;
                index_q <= '0;
                state_q <= ST_IDLE;
              end else begin
                index_q <= (index_q == LAST_IDX) ? '0 : index_q + ADDR_W'(1);
                state_q <= (pause || pause_pend_q) ? ST_PAUSED : ST_WAIT_TICK;
              end
            end
          end
          ST_PAUSED: begin
            if (play) state_q <= ST_WAIT_TICK;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rom_addr     = index_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q != ST_IDLE);
  assign state_dbg    = state_q;

endmodule
